// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: decodes RV32I immediates (I/S/B/U/J) and
// the CSR zimm from a 32-bit instruction, extends them to XLEN and registers
// the result together with a passthrough tag behind a valid/ready handshake.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_EMPTY | no entry held; out_valid=0
// ST_ONE   | main register holds the head entry; can still accept
// ST_TWO   | main and skid both hold entries; in_ready=0 (SKID_EN=1 only)
module imm_gen_pipe #(
   parameter int XLEN    = 32,
   parameter int TAG_W   = 32,
   parameter bit SKID_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
   localparam logic [2:0] FMT_Z    = 3'd6;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic              in_ready_q;

   logic [31:0]       dec_imm32;
   logic              dec_sext;
   logic [2:0]        dec_fmt;
   logic [XLEN-1:0]   dec_imm;

   logic [XLEN-1:0]   main_imm;
   logic [2:0]        main_fmt;
   logic [TAG_W-1:0]  main_tag;
   logic [XLEN-1:0]   skid_imm;
   logic [2:0]        skid_fmt;
   logic [TAG_W-1:0]  skid_tag;

   logic              accept;
   logic              drain;
   logic              load_main_in;
   logic              load_main_skid;
   logic              load_skid_in;

   // Immediate decode, assembled as 32 bits; extension to XLEN happens below
   always_comb begin
      dec_imm32 = '0;
      dec_sext  = 1'b0;
      dec_fmt   = FMT_NONE;
      case (in_instr[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: begin
            dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            dec_sext  = 1'b1;
            dec_fmt   = FMT_I;
         end
         7'b0100011: begin
            dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            dec_sext  = 1'b1;
            dec_fmt   = FMT_S;
         end
         7'b1100011: begin
            dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
            dec_sext  = 1'b1;
            dec_fmt   = FMT_B;
         end
         7'b0110111, 7'b0010111: begin
            dec_imm32 = {in_instr[31:12], 12'b0};
            dec_sext  = 1'b1;
            dec_fmt   = FMT_U;
         end
         7'b1101111: begin
            dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            dec_sext  = 1'b1;
            dec_fmt   = FMT_J;
         end
         7'b1110011: begin
            // only the immediate CSR forms (funct3[2]=1) carry a zimm
            if (in_instr[14]) begin
               dec_imm32 = {27'b0, in_instr[19:15]};
               dec_fmt   = FMT_Z;
            end
         end
         default: ;
      endcase
   end

   // U-type included: with XLEN=64 every signed format extends from bit 31
   assign dec_imm = dec_sext ? XLEN'($signed(dec_imm32)) : XLEN'(dec_imm32);

   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;

   generate
      if (SKID_EN) begin : g_skid_ready
         assign in_ready = in_ready_q;
      end else begin : g_pass_ready
         assign in_ready = !out_valid || out_ready;
      end
   endgenerate

   // Next-state and register-load steering
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d      = ST_ONE;
               load_main_in = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && drain) begin
               load_main_in = 1'b1;
            end else if (accept) begin
               state_d      = ST_TWO;
               load_skid_in = 1'b1;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (drain) begin
               state_d        = ST_ONE;
               load_main_skid = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // State register; in_ready is precomputed so it never depends on out_ready
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != ST_TWO);
      end
   end

   // Entry storage; data is left untouched when draining to empty
   always_ff @(posedge clk) begin
      if (reset) begin
         main_imm <= '0;
         main_fmt <= '0;
         main_tag <= '0;
         skid_imm <= '0;
         skid_fmt <= '0;
         skid_tag <= '0;
      end else begin
         if (load_main_in) begin
            main_imm <= dec_imm;
            main_fmt <= dec_fmt;
            main_tag <= in_tag;
         end else if (load_main_skid) begin
            main_imm <= skid_imm;
            main_fmt <= skid_fmt;
            main_tag <= skid_tag;
         end
         if (load_skid_in) begin
            skid_imm <= dec_imm;
            skid_fmt <= dec_fmt;
            skid_tag <= in_tag;
         end
      end
   end

   assign out_imm = main_imm;
   assign out_fmt = main_fmt;
   assign out_tag = main_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit skid-buffered instance checked against a
// queue-based scoreboard, plus a 64-bit single-stage instance.
module tb_imm_gen_pipe;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_imm;
   logic [2:0]  out_fmt;
   logic [31:0] out_tag;

   logic        v64;
   logic        rdy64;
   logic [31:0] ins64;
   logic [7:0]  tag64;
   logic        ov64;
   logic        ordy64;
   logic [63:0] imm64;
   logic [2:0]  fmt64;
   logic [7:0]  otag64;

   imm_gen_pipe #(.XLEN(32), .TAG_W(32), .SKID_EN(1'b1)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_imm(out_imm), .out_fmt(out_fmt), .out_tag(out_tag)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(8), .SKID_EN(1'b0)) dut64 (
      .clk(clk), .reset(reset),
      .in_valid(v64), .in_ready(rdy64),
      .in_instr(ins64), .in_tag(tag64),
      .out_valid(ov64), .out_ready(ordy64),
      .out_imm(imm64), .out_fmt(fmt64), .out_tag(otag64)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic [31:0] tag;
   } entry_t;

   entry_t      sb[$];
   int          total = 0;
   int          bad = 0;
   int          n_drain = 0;
   bit          prev_stall = 0;
   bit          prev_idle = 0;
   logic [31:0] prev_imm;
   logic [2:0]  prev_fmt;
   logic [31:0] prev_tag;

   task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, obs, exp);
      end
   endtask

   // Reference decode using signed arithmetic on the field values
   function automatic void ref_dec(input logic [31:0] ins, input int xlen,
                                   output logic [63:0] imm, output logic [2:0] fmt);
      longint v;
      v = 0;
      fmt = 3'd0;
      case (ins[6:0])
         7'h13, 7'h03, 7'h67: begin
            fmt = 3'd1;
            v = longint'(ins[31:20]);
            if (ins[31]) v -= 4096;
         end
         7'h23: begin
            fmt = 3'd2;
            v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
            if (ins[31]) v -= 4096;
         end
         7'h63: begin
            fmt = 3'd3;
            v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            if (ins[31]) v -= 4096;
         end
         7'h37, 7'h17: begin
            fmt = 3'd4;
            v = longint'(ins[31:12]) * 4096;
            if (ins[31]) v -= (longint'(1) << 32);
         end
         7'h6F: begin
            fmt = 3'd5;
            v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            if (ins[31]) v -= (longint'(1) << 20);
         end
         7'h73: begin
            if (ins[14]) begin
               fmt = 3'd6;
               v = longint'(ins[19:15]);
            end
         end
         default: ;
      endcase
      imm = 64'(v);
      if (xlen == 32) imm[63:32] = 32'h0;
   endfunction

   function automatic logic [31:0] rnd_instr();
      logic [6:0]  ops[10];
      logic [31:0] r;
      int          k;
      ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h00};
      r = $urandom;
      k = $urandom_range(0, 9);
      if (k == 9) return r;
      return {r[31:7], ops[k]};
   endfunction

   // One cycle on the main instance: called at a negedge, returns at the next
   task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] tg,
                       input bit ordy, input bit rst);
      entry_t e;
      logic [63:0] eimm;
      logic [2:0]  efmt;
      in_valid  = v;
      in_instr  = ins;
      in_tag    = tg;
      out_ready = ordy;
      reset     = rst;
      #1;
      if (rst) begin
         sb.delete();
         prev_stall = 0;
         prev_idle  = 0;
      end else begin
         check_val("out_valid", 64'(out_valid), 64'(sb.size() > 0));
         check_val("in_ready", 64'(in_ready), 64'(sb.size() < 2));
         if (prev_stall) begin
            check_val("stall_imm", 64'(out_imm), 64'(prev_imm));
            check_val("stall_fmt", 64'(out_fmt), 64'(prev_fmt));
            check_val("stall_tag", 64'(out_tag), 64'(prev_tag));
         end
         if (prev_idle && !out_valid) begin
            check_val("idle_imm", 64'(out_imm), 64'(prev_imm));
            check_val("idle_fmt", 64'(out_fmt), 64'(prev_fmt));
         end
         if (out_valid && out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            check_val("drain_imm", 64'(out_imm), e.imm);
            check_val("drain_fmt", 64'(out_fmt), 64'(e.fmt));
            check_val("drain_tag", 64'(out_tag), 64'(e.tag));
            n_drain++;
         end
         if (in_valid && in_ready) begin
            ref_dec(in_instr, 32, eimm, efmt);
            e.imm = eimm;
            e.fmt = efmt;
            e.tag = in_tag;
            sb.push_back(e);
         end
         prev_stall = out_valid && !out_ready;
         prev_idle  = !out_valid;
      end
      prev_imm = out_imm;
      prev_fmt = out_fmt;
      prev_tag = out_tag;
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [31:0] d_ins[7];
   logic [31:0] d_imm[7];
   logic [2:0]  d_fmt[7];

   initial begin
      logic [63:0] eimm;
      logic [2:0]  efmt;
      int          base;

      d_ins = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123452B7,
                32'h001000EF, 32'h300FD073, 32'h0000000B};
      d_imm = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                32'h00000800, 32'h0000001F, 32'h00000000};
      d_fmt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};

      reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
      v64 = 1'b0; ins64 = '0; tag64 = '0; ordy64 = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_valid", 64'(out_valid), 64'd0);
      check_val("rst_imm", 64'(out_imm), 64'd0);
      check_val("rst_fmt", 64'(out_fmt), 64'd0);
      check_val("rst_tag", 64'(out_tag), 64'd0);
      check_val("rst_ready", 64'(in_ready), 64'd1);
      check_val("rst_valid64", 64'(ov64), 64'd0);

      // directed formats, one cycle latency
      for (int i = 0; i < 7; i++) begin
         step(1'b1, d_ins[i], 32'(16 + i), 1'b1, 1'b0);
         check_val("lat_valid", 64'(out_valid), 64'd1);
         check_val("dir_imm", 64'(out_imm), 64'(d_imm[i]));
         check_val("dir_fmt", 64'(out_fmt), 64'(d_fmt[i]));
         check_val("dir_tag", 64'(out_tag), 64'(16 + i));
      end
      step(1'b0, '0, '0, 1'b1, 1'b0);

      // backpressure: tags 1,2 accepted, 3 held until downstream resumes
      step(1'b1, d_ins[0], 32'd1, 1'b0, 1'b0);
      step(1'b1, d_ins[1], 32'd2, 1'b0, 1'b0);
      check_val("bp_ready", 64'(in_ready), 64'd0);
      repeat (3) step(1'b1, d_ins[2], 32'd3, 1'b0, 1'b0);
      check_val("bp_head", 64'(out_tag), 64'd1);
      repeat (3) step(1'b1, d_ins[2], 32'd3, 1'b1, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b0);

      // full throughput
      base = n_drain;
      for (int i = 0; i < 20; i++) step(1'b1, rnd_instr(), 32'(32'h40 + i), 1'b1, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b0);
      check_val("thru_count", 64'(n_drain - base), 64'd20);

      // reset while two entries are held
      step(1'b1, rnd_instr(), 32'h100, 1'b0, 1'b0);
      step(1'b1, rnd_instr(), 32'h101, 1'b0, 1'b0);
      check_val("two_ready", 64'(in_ready), 64'd0);
      step(1'b1, rnd_instr(), 32'h102, 1'b0, 1'b1);
      check_val("mid_valid", 64'(out_valid), 64'd0);
      check_val("mid_imm", 64'(out_imm), 64'd0);
      check_val("mid_fmt", 64'(out_fmt), 64'd0);
      check_val("mid_ready", 64'(in_ready), 64'd1);

      // random traffic with independent stalls on both sides
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, rnd_instr(), 32'(32'h200 + i),
              $urandom_range(0, 3) != 0, 1'b0);
      repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);

      // 64-bit single-stage instance
      v64 = 1'b1; ins64 = 32'hFFF00093; tag64 = 8'd1; ordy64 = 1'b1;
      #1 check_val("r64_ready", 64'(rdy64), 64'd1);
      @(posedge clk); @(negedge clk);
      v64 = 1'b0; ordy64 = 1'b0;
      check_val("x64_imm_i", imm64, 64'hFFFFFFFFFFFFFFFF);
      check_val("x64_fmt_i", 64'(fmt64), 64'd1);
      check_val("x64_tag_i", 64'(otag64), 64'd1);
      #1 check_val("x64_ready_stall", 64'(rdy64), 64'd0);
      ordy64 = 1'b1; v64 = 1'b1; ins64 = 32'h800000B7; tag64 = 8'd2;
      #1 check_val("x64_ready_drain", 64'(rdy64), 64'd1);
      @(posedge clk); @(negedge clk);
      v64 = 1'b0;
      check_val("x64_imm_u", imm64, 64'hFFFFFFFF80000000);
      check_val("x64_fmt_u", 64'(fmt64), 64'd4);
      check_val("x64_tag_u", 64'(otag64), 64'd2);
      for (int i = 0; i < 40; i++) begin
         v64 = 1'b1; ins64 = rnd_instr(); tag64 = 8'(i + 3); ordy64 = 1'b1;
         ref_dec(ins64, 64, eimm, efmt);
         @(posedge clk); @(negedge clk);
         v64 = 1'b0;
         check_val("x64_rnd_valid", 64'(ov64), 64'd1);
         check_val("x64_rnd_imm", imm64, eimm);
         check_val("x64_rnd_fmt", 64'(fmt64), 64'(efmt));
         check_val("x64_rnd_tag", 64'(otag64), 64'(i + 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
